// File: rtl/mdclcg_pkg.sv
// Shared definitions for the dual-CLCG word generator: FSM encoding and default sizes.
package mdclcg_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHold = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_OUT_W = 8;
   localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/lcg_step.sv
// One combinational LCG step: (a * s + b) mod 2^WIDTH.
module lcg_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_s,
   output logic [WIDTH-1:0] o_s
);

   // Self-determined WIDTH-bit arithmetic keeps only the low bits of the product.
   assign o_s = i_a * i_s + i_b;

endmodule

// File: rtl/mdclcg_word_gen.sv
// Modified dual-CLCG generator: four coupled LCGs, bits kept when p <= q, packed into
// OUT_W-bit words on a valid/ready stream with a saturating discard counter.
module mdclcg_word_gen
   import mdclcg_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned OUT_W = DEF_OUT_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic [WIDTH-1:0] i_a1,
   input  logic [WIDTH-1:0] i_b1,
   input  logic [WIDTH-1:0] i_a2,
   input  logic [WIDTH-1:0] i_b2,
   input  logic [WIDTH-1:0] i_seed_x,
   input  logic [WIDTH-1:0] i_seed_y,
   input  logic [WIDTH-1:0] i_seed_p,
   input  logic [WIDTH-1:0] i_seed_q,
   output logic [OUT_W-1:0] o_out_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_busy,
   output logic             o_cfg_ok,
   output logic [CNT_W-1:0] o_disc_cnt
);

   localparam int unsigned BC_W = $clog2(OUT_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(OUT_W - 1);

   state_t             r_state, w_state_d;
   logic [WIDTH-1:0]   r_a1, r_b1, r_a2, r_b2, w_a1_d, w_b1_d, w_a2_d, w_b2_d;
   logic [WIDTH-1:0]   r_x, r_y, r_p, r_q, w_x_d, w_y_d, w_p_d, w_q_d;
   logic [WIDTH-1:0]   w_x_nxt, w_y_nxt, w_p_nxt, w_q_nxt;
   logic [OUT_W-2:0]   r_shift, w_shift_d;
   logic [BC_W-1:0]    r_bitcnt, w_bitcnt_d;
   logic [OUT_W-1:0]   r_out_data, w_out_data_d, w_word;
   logic               r_out_valid, w_out_valid_d;
   logic               r_cfg_ok, w_cfg_ok_d;
   logic [CNT_W-1:0]   r_disc_cnt, w_disc_cnt_d;
   logic               w_b, w_c, w_advance, w_cfg_in;

   lcg_step #(.WIDTH(WIDTH)) u_lcg_x (.i_a(r_a1), .i_b(r_b1), .i_s(r_x), .o_s(w_x_nxt));
   lcg_step #(.WIDTH(WIDTH)) u_lcg_y (.i_a(r_a2), .i_b(r_b2), .i_s(r_y), .o_s(w_y_nxt));
   lcg_step #(.WIDTH(WIDTH)) u_lcg_p (.i_a(r_a1), .i_b(r_b1), .i_s(r_p), .o_s(w_p_nxt));
   lcg_step #(.WIDTH(WIDTH)) u_lcg_q (.i_a(r_a2), .i_b(r_b2), .i_s(r_q), .o_s(w_q_nxt));

   assign w_b      = (w_x_nxt > w_y_nxt);
   assign w_c      = (w_p_nxt > w_q_nxt);
   assign w_word   = {r_shift, w_b};
   assign w_cfg_in = (i_a1[1:0] == 2'b01) & i_b1[0] & (i_a2[1:0] == 2'b01) & i_b2[0];

   always_comb begin
      w_state_d     = r_state;
      w_a1_d        = r_a1;
      w_b1_d        = r_b1;
      w_a2_d        = r_a2;
      w_b2_d        = r_b2;
      w_x_d         = r_x;
      w_y_d         = r_y;
      w_p_d         = r_p;
      w_q_d         = r_q;
      w_shift_d     = r_shift;
      w_bitcnt_d    = r_bitcnt;
      w_out_data_d  = r_out_data;
      w_out_valid_d = r_out_valid;
      w_cfg_ok_d    = r_cfg_ok;
      w_disc_cnt_d  = r_disc_cnt;
      w_advance     = 1'b0;

      if (i_start) begin
         w_state_d     = StRun;
         w_a1_d        = i_a1;
         w_b1_d        = i_b1;
         w_a2_d        = i_a2;
         w_b2_d        = i_b2;
         w_x_d         = i_seed_x;
         w_y_d         = i_seed_y;
         w_p_d         = i_seed_p;
         w_q_d         = i_seed_q;
         w_shift_d     = '0;
         w_bitcnt_d    = '0;
         w_out_valid_d = 1'b0;
         w_cfg_ok_d    = w_cfg_in;
         w_disc_cnt_d  = '0;
      end else if (i_stop && (r_state != StIdle)) begin
         w_state_d     = StIdle;
         w_out_valid_d = 1'b0;
         w_shift_d     = '0;
         w_bitcnt_d    = '0;
      end else begin
         unique case (r_state)
            StIdle: ;
            StRun: begin
               // A stalled word freezes the generator immediately so it cannot be overwritten.
               if (r_out_valid && !i_out_ready) w_state_d = StHold;
               else                             w_advance = 1'b1;
            end
            StHold: begin
               if (i_out_ready) begin
                  w_out_valid_d = 1'b0;
                  w_state_d     = StRun;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end

      if (w_advance) begin
         w_x_d         = w_x_nxt;
         w_y_d         = w_y_nxt;
         w_p_d         = w_p_nxt;
         w_q_d         = w_q_nxt;
         w_out_valid_d = 1'b0;
         if (!w_c) begin
            w_shift_d = w_word[OUT_W-2:0];
            if (r_bitcnt == LAST_BIT) begin
               w_out_data_d  = w_word;
               w_out_valid_d = 1'b1;
               w_bitcnt_d    = '0;
            end else begin
               w_bitcnt_d = r_bitcnt + 1'b1;
            end
         end else if (r_disc_cnt != '1) begin
            w_disc_cnt_d = r_disc_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_a1        <= '0;
         r_b1        <= '0;
         r_a2        <= '0;
         r_b2        <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_p         <= '0;
         r_q         <= '0;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_cfg_ok    <= 1'b0;
         r_disc_cnt  <= '0;
      end else begin
         r_state     <= w_state_d;
         r_a1        <= w_a1_d;
         r_b1        <= w_b1_d;
         r_a2        <= w_a2_d;
         r_b2        <= w_b2_d;
         r_x         <= w_x_d;
         r_y         <= w_y_d;
         r_p         <= w_p_d;
         r_q         <= w_q_d;
         r_shift     <= w_shift_d;
         r_bitcnt    <= w_bitcnt_d;
         r_out_data  <= w_out_data_d;
         r_out_valid <= w_out_valid_d;
         r_cfg_ok    <= w_cfg_ok_d;
         r_disc_cnt  <= w_disc_cnt_d;
      end
   end

   assign o_out_data  = r_out_data;
   assign o_out_valid = r_out_valid;
   assign o_busy      = (r_state != StIdle);
   assign o_cfg_ok    = r_cfg_ok;
   assign o_disc_cnt  = r_disc_cnt;

endmodule

// File: doc/mdclcg_word_gen.md
Name: mdclcg_word_gen

Overview:
- Parametrised successor to the modified dual-CLCG bit generator.
- Four coupled LCGs (x, y, p, q), each mod 2^WIDTH, advance once per cycle.
- B = (x > y) and C = (p > q). The bit B is kept only when C = 0; otherwise it is discarded.
- Kept bits are packed into OUT_W-bit words and delivered over a valid/ready stream with backpressure. This replaces the free-running single-bit z_i output.

Parameters:
- WIDTH, 16, width of LCG state, coefficients and seeds.
- OUT_W, 8, bits per output word (2..32).
- CNT_W, 16, width of the saturating discard counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- start  input  1  pulse; snapshots coefficients and seeds, then begins generation.
- stop  input  1  pulse; halts generation and returns to IDLE.
- a1, b1  input  WIDTH  multiplier and increment for the x and p LCGs.
- a2, b2  input  WIDTH  multiplier and increment for the y and q LCGs.
- seed_x, seed_y, seed_p, seed_q  input  WIDTH  initial LCG states.
- out_data  output  OUT_W  packed word; the first kept bit is at the MSB.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word.
- busy  output  1  high in RUN or HOLD.
- cfg_ok  output  1  registered full-period check: (a1 mod 4 = 1) and b1 odd and (a2 mod 4 = 1) and b2 odd.
- disc_cnt  output  CNT_W  count of discarded bits since start; saturates at all-ones.

Behaviour:
- Reset (rst = 0, async): all of the following go to 0.
  - State is IDLE.
  - All LCG and coefficient registers.
  - Shift register and bit counter.
  - out_data, out_valid, busy, cfg_ok, disc_cnt.
- Arithmetic: s_next = (a * s + b) mod 2^WIDTH, keeping the low WIDTH bits of the product. Comparisons are unsigned.
- B and C are computed from the next-state values, so the first generated bit uses the first advanced states.
- State IDLE:
  - start = 1: at the next edge, load the coefficient and seed registers, compute cfg_ok, clear the shift register, bit counter and disc_cnt, and go to RUN.
  - start = 0: hold.
- State RUN, on each edge:
  - All four LCGs advance.
  - C = 0: shift B into the LSB and increment the bit counter.
  - C = 1: increment disc_cnt (saturating); the bit counter is unchanged.
  - When a kept bit makes the count reach OUT_W: register out_data, set out_valid = 1, clear the bit counter.
- Handshake:
  - A word transfers on an edge where out_valid and out_ready are both 1.
  - If out_valid = 1 and out_ready = 0, go to HOLD. In HOLD the LCGs, counters and out_data are frozen and out_valid stays 1.
  - HOLD and out_ready = 1: transfer the word, drop out_valid at the edge, return to RUN. The LCGs do not advance on that edge.
  - RUN with out_valid = 1 and out_ready = 1: transfer the word and advance the LCGs on the same edge. A newly completed word may set out_valid again, giving continuous throughput.
- Latency with C always 0: out_valid rises OUT_W edges after the load edge.
- busy = 1 in RUN and HOLD.
- stop = 1 in RUN or HOLD: at the next edge go to IDLE, clear out_valid, and drop any partial word. LCG state and disc_cnt are retained.
- start = 1 in RUN or HOLD: reload exactly as from IDLE (restart).
  - start and stop high together: start wins.
- cfg_ok is informational only; generation proceeds regardless of its value.
- Wrap-around of the LCG states is natural mod 2^WIDTH. disc_cnt never wraps.

Decomposition:
- Package mdclcg_pkg holds:
  - State encoding: IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2.
  - Default WIDTH, OUT_W and CNT_W constants.
- Sub-module lcg_step (parameter WIDTH): combinational (a * s + b) mod 2^WIDTH. It is instantiated four times.
- FSM, comparators, packer and counters live in the top module.

Test Plan:
- Always-keep: a1 = a2 = 1, b1 = b2 = 1, seed_x = 5, seed_y = 3, seed_p = 0, seed_q = 1, out_ready = 1, start pulse.
  - out_valid rises 8 edges after load, out_data = 8'hFF.
  - Words then repeat every 8 cycles; disc_cnt stays 0.
- Always-discard: same as always-keep but seed_p = 1, seed_q = 0.
  - out_valid never rises; disc_cnt increments by 1 per cycle.
  - Forcing the counter to 16'hFFFE: it reaches 16'hFFFF and holds.
- Backpressure: always-keep setup with out_ready = 0 when the first word appears.
  - out_valid is held and the LCG state is frozen for 5 cycles.
  - Raising out_ready transfers exactly one 8'hFF, and the next word follows 8 cycles later.
- cfg_ok: a1 = 16'h0002, all else as always-keep -> cfg_ok = 0 and generation still runs. With a1 = a2 = 16'h0005 and b1 = b2 = 16'h3 -> cfg_ok = 1.
- Restart and stop: start pulse mid-word -> partial word dropped, a fresh word is emitted 8 edges after the reload. start and stop together -> start wins (reload, busy = 1). stop alone -> IDLE next edge, out_valid = 0, busy = 0.
- Async reset mid-RUN with out_valid = 1: rst low between clock edges -> all outputs read 0 immediately, and the block stays in IDLE after release until the next start.
